// File: rtl/operand_load_if.sv
// operand_load_if: start/operand-stream/handshake bundle between the operand loader and its neighbours
// slave modport: loader side (inputs beg_op, in_valid, Data_in, ack_op; outputs busy, load_a, load_b, Op_A, Op_B, ready, timeout_err)
// master modport: driving/observing side with the same signals in the opposite direction
interface operand_load_if #(parameter int W = 5);
  logic beg_op;
  logic in_valid;
  logic [W-1:0] Data_in;
  logic ack_op;
  logic busy;
  logic load_a;
  logic load_b;
  logic [W-1:0] Op_A;
  logic [W-1:0] Op_B;
  logic ready;
  logic timeout_err;
  modport slave (
    input beg_op, in_valid, Data_in, ack_op,
    output busy, load_a, load_b, Op_A, Op_B, ready, timeout_err
  );
  modport master (
    output beg_op, in_valid, Data_in, ack_op,
    input busy, load_a, load_b, Op_A, Op_B, ready, timeout_err
  );
endinterface

// File: rtl/operand_load_fsm.sv
// operand_load_fsm: captures operands A then B from a serial bus, presents them with ready/ack, aborts stalled loads via watchdog
// clk/rst: clock and async active-high reset; bus: operand_load_if.slave carrying start, operand stream, strobes, operands and status
module operand_load_fsm #(
  parameter int W = 5,
  parameter int TIMEOUT = 15,
  parameter int CW = 4
) (
  input logic clk,
  input logic rst,
  operand_load_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, READY} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] wd_q, wd_d;
  logic [W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic err_q, err_d;
  logic expired;
  assign expired = wd_q == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wd_q <= '0;
      op_a_q <= '0;
      op_b_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q <= wd_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      err_q <= err_d;
    end
  end
  // The watchdog defaults to zero so it clears on every state change and only counts while a load state is held
  always_comb begin
    state_d = state_q;
    wd_d = '0;
    op_a_d = op_a_q;
    op_b_d = op_b_q;
    err_d = err_q;
    unique case (state_q)
      IDLE: if (bus.beg_op) begin
        state_d = LOAD_A;
        err_d = 1'b0;
      end
      LOAD_A: if (bus.in_valid) begin
        state_d = LOAD_B;
        op_a_d = bus.Data_in;
      end else if (expired) begin
        state_d = IDLE;
        err_d = 1'b1;
      end else wd_d = wd_q + 1'b1;
      LOAD_B: if (bus.in_valid) begin
        state_d = READY;
        op_b_d = bus.Data_in;
      end else if (expired) begin
        state_d = IDLE;
        err_d = 1'b1;
      end else wd_d = wd_q + 1'b1;
      READY: if (bus.ack_op) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  assign bus.load_a = state_q == LOAD_A && bus.in_valid;
  assign bus.load_b = state_q == LOAD_B && bus.in_valid;
  assign bus.busy = state_q != IDLE;
  assign bus.ready = state_q == READY;
  assign bus.Op_A = op_a_q;
  assign bus.Op_B = op_b_q;
  assign bus.timeout_err = err_q;
endmodule

// File: doc/operand_load_fsm.md
Name: operand_load_fsm

Overview:
- Control-plus-capture stage directly upstream of the enabled D flip-flop registers.
- Takes a start request and a serial operand stream on one W-bit bus, and generates the per-register load strobes.
- Holds operands A and B in internal enabled registers and presents them to the downstream datapath with a ready/ack handshake.
- Includes a watchdog that aborts a stalled load.

Parameters:
- W, 5, operand width in bits.
- TIMEOUT, 15, maximum cycles to wait for in_valid in a load state; must be at least 1.
- CW, 4, watchdog counter width; must satisfy 2**CW > TIMEOUT.

Ports:
- clk, input, 1, system clock; all state changes on its rising edge.
- rst, input, 1, system reset; asynchronous, active-high.
- beg_op, input, 1, start request; sampled only in IDLE.
- in_valid, input, 1, Data_in carries a valid operand this cycle.
- Data_in, input, W, serial operand bus.
- ack_op, input, 1, downstream has consumed Op_A/Op_B.
- busy, output, 1, FSM is not in IDLE.
- load_a, output, 1, combinational strobe: Data_in is written into Op_A at this edge.
- load_b, output, 1, combinational strobe: Data_in is written into Op_B at this edge.
- Op_A, output, W, registered operand A.
- Op_B, output, W, registered operand B.
- ready, output, 1, Op_A/Op_B are valid and stable.
- timeout_err, output, 1, sticky flag: a load aborted on watchdog expiry.

Behaviour:
- Reset (async, rst=1): state=IDLE, Op_A=0, Op_B=0, watchdog=0, ready=0, busy=0, timeout_err=0. Outputs take these values immediately, without waiting for a clock edge.
- States: IDLE, LOAD_A, LOAD_B, READY.
- IDLE:
  - beg_op=1 -> LOAD_A next cycle.
  - timeout_err is cleared on that same beg_op edge.
  - in_valid and ack_op are ignored.
- LOAD_A:
  - load_a = in_valid.
  - When in_valid=1: Op_A <= Data_in, watchdog <= 0, go to LOAD_B.
  - Otherwise watchdog increments.
  - If watchdog==TIMEOUT-1 and in_valid=0: go to IDLE, timeout_err <= 1, Op_A/Op_B keep their old values.
- LOAD_B:
  - Same rules as LOAD_A, using load_b and Op_B.
  - On capture, go to READY.
- READY:
  - ready=1.
  - Op_A/Op_B are frozen; in_valid is ignored and no load strobes are asserted.
  - ack_op=1 -> IDLE next cycle.
- Watchdog counting:
  - The counter is cleared on every state change.
  - It counts only in LOAD_A/LOAD_B while in_valid=0.
  - Worst case, a load state is exited exactly TIMEOUT cycles after entry.
- Latency:
  - beg_op accepted at edge n; in_valid held high from cycle n+1 onward.
  - Op_A captured at edge n+1; Op_B captured at edge n+2.
  - ready=1 from edge n+2 until the edge where ack_op is sampled.
- Strobes: load_a and load_b are never high together. Both are 0 outside their own state.
- busy = (state != IDLE). ready = (state == READY). Both are registered-state decodes, so they are glitch-free.
- Simultaneous events:
  - beg_op while busy: ignored, no queuing.
  - ack_op outside READY: ignored.
  - in_valid=1 at the timeout edge: the capture wins and no error is raised.
- Back-to-back operation: beg_op=1 in the cycle after returning to IDLE starts a new operation. The old Op_A/Op_B stay visible until they are overwritten.
- Reset mid-operation: state returns to IDLE at once and Op_A/Op_B are cleared. A load in progress is lost.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with random inputs -> Op_A=0, Op_B=0, ready=0, busy=0, timeout_err=0; beg_op held low keeps the FSM in IDLE.
- Nominal load: beg_op pulse, then in_valid=1 with Data_in=5'b11001 then 5'b00110 on consecutive cycles -> Op_A=11001, Op_B=00110, one load_a pulse then one load_b pulse, ready=1 two edges after beg_op; ack_op -> IDLE with operands unchanged.
- Gapped input: 3 idle cycles before each in_valid -> same results as the nominal load; load strobes appear only on valid cycles; no timeout.
- Watchdog: beg_op, no in_valid for 15 cycles -> return to IDLE on the 15th cycle, timeout_err=1, Op_A unchanged; next beg_op clears timeout_err. Repeat with in_valid asserted on cycle 15 -> capture occurs and no error.
- Ignored events: beg_op during LOAD_B, ack_op during LOAD_A, in_valid=1 with Data_in=5'b11111 in READY -> no state or operand change.
- Async reset mid-load: rst=1 asserted between clock edges in LOAD_B -> busy=0 and Op_A=0 before the next edge; after release, a fresh load completes normally.
